audio_gain_stage: RTL and testbench

AUDIO_GAIN_STAGE -- requirements
Module: audio_gain_stage

---
 rtl/audio_gain_stage_if.sv | 26 ++
 rtl/audio_gain_stage.sv | 140 ++++++++++++++
 tb/tb_audio_gain_stage.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/audio_gain_stage_if.sv
// Codec-side bus for audio_gain_stage: record samples and gain control in,
// processed play samples and status out.
interface audio_gain_stage_if #(
   parameter int N = 24
);
   logic         NewFrame;
   logic [N-1:0] LeftRecData;
   logic [N-1:0] RightRecData;
   logic [7:0]   gain_target;
   logic         mute;
   logic [N-1:0] LeftPlayData;
   logic [N-1:0] RightPlayData;
   logic         busy;
   logic         clip;
   logic         overrun;

   modport master (
      output NewFrame, LeftRecData, RightRecData, gain_target, mute,
      input  LeftPlayData, RightPlayData, busy, clip, overrun
   );

   modport slave (
      input  NewFrame, LeftRecData, RightRecData, gain_target, mute,
      output LeftPlayData, RightPlayData, busy, clip, overrun
   );
endinterface

// File: rtl/audio_gain_stage.sv
// Stereo Q2.6 gain stage with one shared 8-cycle shift-add multiplier.
// Optional macro GAIN_RAMP_EN: gain_cur ramps by 1 per frame toward the target.
module audio_gain_stage #(
   parameter int N = 24
) (
   input logic              audio_clk,
   input logic              reset,
   audio_gain_stage_if.slave bus
);
   localparam int P = N + 9;   // signed sample x unsigned 8-bit gain never overflows

   typedef enum logic [1:0] {IDLE, MUL_L, MUL_R, DONE} state_t;

   state_t              state;
   logic [N-1:0]        samp_r;
   logic [7:0]          gain_cur;
   logic [7:0]          mplier;
   logic signed [P-1:0] mcand;
   logic signed [P-1:0] acc;
   logic signed [P-1:0] acc_nxt;
   logic signed [P-1:0] shr;
   logic [2:0]          cnt;
   logic [N-1:0]        res_l, res_r, sat_val;
   logic                clip_l, clip_r, sat_hit;
   logic [7:0]          eff_tgt;
`ifdef GAIN_RAMP_EN
   logic [7:0]          tgt_q;
`endif

   function automatic logic signed [P-1:0] sext(input logic [N-1:0] s);
      return {{(P-N){s[N-1]}}, s};
   endfunction

   assign eff_tgt = bus.mute ? 8'd0 : bus.gain_target;
   assign acc_nxt = acc + (mplier[0] ? mcand : '0);
   assign shr     = acc_nxt >>> 6;

   // In range only when every bit above the output sign bit matches it
   always_comb begin
      sat_hit = ~((&shr[P-1:N-1]) | ~(|shr[P-1:N-1]));
      if (!sat_hit)
         sat_val = shr[N-1:0];
      else if (shr[P-1])
         sat_val = {1'b1, {(N-1){1'b0}}};
      else
         sat_val = {1'b0, {(N-1){1'b1}}};
   end

   always_ff @(posedge audio_clk or posedge reset) begin
      if (reset) begin
         state             <= IDLE;
         samp_r            <= '0;
         gain_cur          <= 8'd64;
         mplier            <= '0;
         mcand             <= '0;
         acc               <= '0;
         cnt               <= '0;
         res_l             <= '0;
         res_r             <= '0;
         clip_l            <= 1'b0;
         clip_r            <= 1'b0;
`ifdef GAIN_RAMP_EN
         tgt_q             <= 8'd64;
`endif
         bus.LeftPlayData  <= '0;
         bus.RightPlayData <= '0;
         bus.busy          <= 1'b0;
         bus.clip          <= 1'b0;
         bus.overrun       <= 1'b0;
      end else begin
         if (bus.NewFrame && state != IDLE)
            bus.overrun <= 1'b1;

         case (state)
            IDLE: begin
               if (bus.NewFrame) begin
                  mcand    <= sext(bus.LeftRecData);
                  samp_r   <= bus.RightRecData;
                  acc      <= '0;
                  cnt      <= '0;
                  bus.busy <= 1'b1;
`ifdef GAIN_RAMP_EN
                  mplier   <= gain_cur;
                  tgt_q    <= eff_tgt;
`else
                  mplier   <= eff_tgt;
                  gain_cur <= eff_tgt;
`endif
                  state    <= MUL_L;
               end
            end

            MUL_L: begin
               cnt <= cnt + 3'd1;
               if (cnt == 3'd7) begin
                  res_l  <= sat_val;
                  clip_l <= sat_hit;
                  acc    <= '0;
                  mcand  <= sext(samp_r);
                  mplier <= gain_cur;   // still the gain this frame started with
                  state  <= MUL_R;
               end else begin
                  acc    <= acc_nxt;
                  mcand  <= mcand <<< 1;
                  mplier <= mplier >> 1;
               end
            end

            MUL_R: begin
               cnt <= cnt + 3'd1;
               if (cnt == 3'd7) begin
                  res_r  <= sat_val;
                  clip_r <= sat_hit;
                  state  <= DONE;
               end else begin
                  acc    <= acc_nxt;
                  mcand  <= mcand <<< 1;
                  mplier <= mplier >> 1;
               end
            end

            DONE: begin
               bus.LeftPlayData  <= res_l;
               bus.RightPlayData <= res_r;
               bus.clip          <= clip_l | clip_r;
               bus.busy          <= 1'b0;
`ifdef GAIN_RAMP_EN
               if (gain_cur < tgt_q)
                  gain_cur <= gain_cur + 8'd1;
               else if (gain_cur > tgt_q)
                  gain_cur <= gain_cur - 8'd1;
`endif
               state <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_audio_gain_stage.sv
// Self-checking bench for audio_gain_stage (default build, no gain ramp).
module tb_audio_gain_stage;
   localparam int N = 24;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   audio_gain_stage_if #(.N(N)) bus ();
   audio_gain_stage #(.N(N)) dut (.audio_clk(clk), .reset(rst), .bus(bus));

   typedef struct {
      logic [23:0] l, r;
      logic [7:0]  g;
      logic        m;
      logic [23:0] el, er;
      logic        ec;
   } vec_t;

   typedef struct {
      logic [23:0] el, er;
      logic        ec;
   } exp_t;

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];
   vec_t tbl[10];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [23:0] sat1(input logic [23:0] s, input logic [7:0] g, output bit c);
      longint p;
      int     gi;
      gi = int'(g);
      p  = longint'($signed(s)) * longint'(gi);
      p  = p >>> 6;
      c  = 1'b0;
      if (p > 64'sd8388607) begin
         c = 1'b1;
         return 24'h7FFFFF;
      end else if (p < -64'sd8388608) begin
         c = 1'b1;
         return 24'h800000;
      end
      return p[23:0];
   endfunction

   function automatic exp_t model(input logic [23:0] l, r, input logic [7:0] g, input logic m);
      exp_t e;
      bit   cl, cr;
      e.el = sat1(l, m ? 8'd0 : g, cl);
      e.er = sat1(r, m ? 8'd0 : g, cr);
      e.ec = cl | cr;
      return e;
   endfunction

   task automatic drive(input logic [23:0] l, r, input logic [7:0] g, input logic m);
      @(negedge clk);
      bus.LeftRecData  = l;
      bus.RightRecData = r;
      bus.gain_target  = g;
      bus.mute         = m;
      bus.NewFrame     = 1'b1;
      @(posedge clk);
      #1;
      bus.NewFrame     = 1'b0;
   endtask

   // Counts edges until busy falls, then pops and compares the oldest expectation.
   task automatic wait_done(input int exp_cyc, input string nm);
      int   cyc;
      exp_t e;
      cyc = 0;
      while (bus.busy && cyc < 40) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      chk({nm, "_latency"}, cyc, exp_cyc);
      if (sb.size() == 0) begin
         chk({nm, "_sb_empty"}, 1, 0);
      end else begin
         e = sb.pop_front();
         chk({nm, "_left"},  bus.LeftPlayData,  e.el);
         chk({nm, "_right"}, bus.RightPlayData, e.er);
         chk({nm, "_clip"},  bus.clip,          e.ec);
      end
   endtask

   task automatic run_frame(input logic [23:0] l, r, input logic [7:0] g, input logic m,
                            input exp_t e, input string nm);
      drive(l, r, g, m);
      sb.push_back(e);
      chk({nm, "_busy_set"}, bus.busy, 1'b1);
      wait_done(17, nm);
   endtask

   initial begin
      exp_t e;
      logic [23:0] rl, rr;
      logic [7:0]  rg;
      logic        rm;

      tbl[0] = '{24'h123456, 24'hFEDCBA, 8'd64,  1'b0, 24'h123456, 24'hFEDCBA, 1'b0};
      tbl[1] = '{24'h400000, 24'hC00000, 8'd255, 1'b0, 24'h7FFFFF, 24'h800000, 1'b1};
      tbl[2] = '{24'h000100, 24'h000100, 8'd255, 1'b0, 24'h0003FC, 24'h0003FC, 1'b0};
      tbl[3] = '{24'h010000, 24'h000000, 8'd70,  1'b0, 24'h011800, 24'h000000, 1'b0};
      tbl[4] = '{24'h100000, 24'hABCDEF, 8'd64,  1'b1, 24'h000000, 24'h000000, 1'b0};
      tbl[5] = '{24'h7FFFFF, 24'h800000, 8'd0,   1'b0, 24'h000000, 24'h000000, 1'b0};
      tbl[6] = '{24'h7FFFFF, 24'h800000, 8'd128, 1'b0, 24'h7FFFFF, 24'h800000, 1'b1};
      tbl[7] = '{24'h7FFFFF, 24'h800000, 8'd64,  1'b0, 24'h7FFFFF, 24'h800000, 1'b0};
      tbl[8] = '{24'hFFFFFF, 24'h00003F, 8'd1,   1'b0, 24'hFFFFFF, 24'h000000, 1'b0};
      tbl[9] = '{24'h000040, 24'hFFFFC0, 8'd96,  1'b0, 24'h000060, 24'hFFFFA0, 1'b0};

      rst = 1'b1;
      bus.NewFrame = 1'b0;
      bus.LeftRecData = '0;
      bus.RightRecData = '0;
      bus.gain_target = 8'd64;
      bus.mute = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_left",    bus.LeftPlayData,  24'h0);
      chk("rst_right",   bus.RightPlayData, 24'h0);
      chk("rst_busy",    bus.busy,          1'b0);
      chk("rst_clip",    bus.clip,          1'b0);
      chk("rst_overrun", bus.overrun,       1'b0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 10; i++) begin
         e = '{tbl[i].el, tbl[i].er, tbl[i].ec};
         run_frame(tbl[i].l, tbl[i].r, tbl[i].g, tbl[i].m, e, $sformatf("vec%0d", i));
         repeat (i % 3) @(posedge clk);
      end
      chk("no_overrun_yet", bus.overrun, 1'b0);

      for (int i = 0; i < 8; i++) begin
         rl = 24'($urandom);
         rr = 24'($urandom);
         rg = 8'($urandom_range(0, 255));
         rm = ($urandom_range(0, 7) == 0);
         run_frame(rl, rr, rg, rm, model(rl, rr, rg, rm), $sformatf("rnd%0d", i));
      end

      // Second pulse five edges into a frame is dropped and flags overrun
      drive(24'h200000, 24'h100000, 8'd32, 1'b0);
      sb.push_back('{24'h100000, 24'h080000, 1'b0});
      repeat (4) @(posedge clk);
      @(negedge clk);
      bus.LeftRecData  = 24'h7FFFFF;
      bus.RightRecData = 24'h7FFFFF;
      bus.gain_target  = 8'd255;
      bus.NewFrame     = 1'b1;
      @(posedge clk);
      #1;
      bus.NewFrame = 1'b0;
      chk("ovr_set",  bus.overrun, 1'b1);
      chk("ovr_busy", bus.busy,    1'b1);
      wait_done(12, "ovr_frame");
      repeat (3) @(posedge clk);
      #1;
      chk("ovr_no_extra_frame", bus.busy, 1'b0);
      run_frame(24'h400000, 24'h000010, 8'd255, 1'b0,
                '{24'h7FFFFF, 24'h00003F, 1'b1}, "post_ovr");
      chk("ovr_sticky", bus.overrun, 1'b1);

      // Reset in the middle of the right-channel multiply
      drive(24'h123456, 24'h654321, 8'd64, 1'b0);
      repeat (11) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_left",    bus.LeftPlayData,  24'h0);
      chk("midrst_right",   bus.RightPlayData, 24'h0);
      chk("midrst_busy",    bus.busy,          1'b0);
      chk("midrst_clip",    bus.clip,          1'b0);
      chk("midrst_overrun", bus.overrun,       1'b0);
      @(negedge clk);
      rst = 1'b0;
      run_frame(24'h0ABCDE, 24'hF00001, 8'd64, 1'b0,
                '{24'h0ABCDE, 24'hF00001, 1'b0}, "after_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
